// File: rtl/weight_stream_reader_pkg.sv
// Shared defaults and state encoding for the weight-memory blocks.
package weight_stream_reader_pkg;

  localparam int WS_DEPTH  = 28;
  localparam int WS_ADDR_W = 5;
  localparam int WS_DATA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage : weight_stream_reader_pkg

// File: rtl/weight_stream_reader_if.sv
// BRAM read port plus the downstream weight stream handshake.
interface weight_stream_reader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 16
) ();

  logic [ADDR_W-1:0] BRAM_ADDR;
  logic              BRAM_EN;
  logic              BRAM_WE;
  logic [DATA_W-1:0] BRAM_DO;
  logic [DATA_W-1:0] W_DATA;
  logic              W_VALID;
  logic              W_LAST;
  logic              W_READY;

  // Reader side: drives the BRAM request and the stream.
  modport master (
    output BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_VALID, W_LAST,
    input  BRAM_DO, W_READY
  );

  // Environment side: BRAM and downstream consumer.
  modport slave (
    input  BRAM_ADDR, BRAM_EN, BRAM_WE, W_DATA, W_VALID, W_LAST,
    output BRAM_DO, W_READY
  );

endinterface : weight_stream_reader_if

// File: rtl/weight_skid_fifo.sv
// Two-entry FIFO holding weight words plus their last tag.
module weight_skid_fifo
  import weight_stream_reader_pkg::*;
#(
  parameter int DATA_W = WS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              last_i,
  output logic [DATA_W-1:0] data_o,
  output logic              last_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] data_q [2];
  logic              last_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic              do_push;
  logic              do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Head of the queue; zero when empty so the stream outputs stay quiet.
  assign data_o = empty_o ? '0 : data_q[rd_ptr_q];
  assign last_o = ~empty_o & last_q[rd_ptr_q];

  // Storage, pointers and occupancy; push and pop together leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: only two entries, so the storage is reset too; this keeps the head value defined after reset.
      for (int i = 0; i < 2; i++) begin
        data_q[i] <= '0;
        last_q[i] <= 1'b0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        data_q[wr_ptr_q] <= data_i;
        last_q[wr_ptr_q] <= last_i;
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

endmodule : weight_skid_fifo

// File: rtl/weight_stream_reader.sv
// Streams DEPTH weight words from a BRAM into a valid/ready stream.
module weight_stream_reader
  import weight_stream_reader_pkg::*;
#(
  parameter int DEPTH  = WS_DEPTH,
  parameter int ADDR_W = WS_ADDR_W,
  parameter int DATA_W = WS_DATA_W
) (
  input  logic                   CLK,
  input  logic                   RSTN,
  input  logic                   START,
  output logic                   BUSY,
  output logic                   DONE,
  weight_stream_reader_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] issue_q, issue_d;
  logic              issue_w;
  logic              fifo_full;
  logic              fifo_empty;
  logic              head_last;
  logic              pop_w;

  // The BRAM registers data on the falling edge, so a read issued in a cycle
  // is captured at the very next rising edge: nothing stays in flight across
  // an edge, and FIFO occupancy alone is the credit count.
  weight_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk     (CLK),
    .rst_n   (RSTN),
    .push_i  (issue_w),
    .pop_i   (pop_w),
    .data_i  (bus.BRAM_DO),
    .last_i  (issue_q == LAST_ADDR),
    .data_o  (bus.W_DATA),
    .last_o  (head_last),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bus.W_VALID   = ~fifo_empty;
  assign bus.W_LAST    = head_last;
  assign pop_w         = bus.W_VALID & bus.W_READY;
  assign bus.BRAM_EN   = issue_w;
  assign bus.BRAM_ADDR = issue_w ? issue_q : '0;
  assign bus.BRAM_WE   = 1'b0;
  assign BUSY          = (state_q != ST_IDLE);
  assign DONE          = pop_w & head_last;

  // State and issue-address registers.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= ST_IDLE;
      issue_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      issue_q <= issue_d;
    end
  end

  // Next state, read issue under the occupancy credit, address advance.
  always_comb begin
    // NOTE: defaults first so no path leaves a signal unassigned and infers a latch.
    state_d = state_q;
    issue_d = issue_q;
    issue_w = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (START) begin
          state_d = ST_RUN;
          issue_d = '0;
        end
      end
      ST_RUN: begin
        if (!fifo_full) begin
          issue_w = 1'b1;
          if (issue_q == LAST_ADDR) begin
            state_d = ST_DRAIN;
          end else begin
            issue_d = issue_q + ADDR_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pop_w && head_last) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule : weight_stream_reader

// File: tb/tb_weight_stream_reader.sv
// Directed bench for weight_stream_reader with a falling-edge BRAM model.
module tb_weight_stream_reader;

  localparam int DEPTH  = 28;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 16;

  logic CLK;
  logic RSTN;
  logic START;
  logic BUSY;
  logic DONE;

  weight_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  weight_stream_reader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .START (START),
    .BUSY  (BUSY),
    .DONE  (DONE),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  // BRAM model: registers read data on the falling edge.
  logic [DATA_W-1:0] mem [32];
  always @(negedge CLK) begin
    if (bus.BRAM_EN === 1'b1) bus.BRAM_DO <= mem[bus.BRAM_ADDR];
  end

  // Write-enable watch across the whole run.
  int we_bad = 0;
  always @(negedge CLK) begin
    if (bus.BRAM_WE !== 1'b0) we_bad++;
  end

  // Per-stream bookkeeping.
  int issued, received, done_n, credit_viol, first_valid;
  logic [DATA_W-1:0] rx_data [64];
  logic              rx_last [64];
  logic [ADDR_W-1:0] iss_addr [64];
  logic s_busy, s_done, s_en, s_valid, s_last;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, then sample and score what happens at the next edge.
  task automatic run_cycle(input logic ready, input logic start, input int k);
    @(posedge CLK);
    #2;
    START       = start;
    bus.W_READY = ready;
    #1;
    s_busy  = BUSY;
    s_done  = DONE;
    s_en    = bus.BRAM_EN;
    s_addr  = bus.BRAM_ADDR;
    s_valid = bus.W_VALID;
    s_last  = bus.W_LAST;
    s_data  = bus.W_DATA;
    if (s_en === 1'b1) begin
      if (issued - received >= 2) credit_viol++;
      if (issued < 64) iss_addr[issued] = s_addr;
      issued++;
    end
    if (s_valid === 1'b1 && first_valid < 0) first_valid = k;
    if (s_valid === 1'b1 && ready) begin
      if (received < 64) begin
        rx_data[received] = s_data;
        rx_last[received] = s_last;
      end
      received++;
    end
    if (s_done === 1'b1) done_n++;
  endtask

  function automatic logic ready_of(input int mode, input int k);
    case (mode)
      1:       return ((k % 4) == 0) || ((k % 4) == 3);
      2:       return (k > 10);
      default: return 1'b1;
    endcase
  endfunction

  // Runs one stream; mode selects the W_READY pattern, restart_at re-pulses START
  // at that word count, abort_at returns early at that word count.
  task automatic stream(input int mode, input int restart_at, input int abort_at, input string tag);
    int  k;
    bit  done_seen;
    bit  restarted;
    logic st;
    issued = 0; received = 0; done_n = 0; credit_viol = 0; first_valid = -1;
    run_cycle(ready_of(mode, 0), 1'b1, 0);
    check({tag, "_busy_before"}, 32'(s_busy), 32'd0);
    done_seen = 0;
    restarted = 0;
    for (k = 1; k < 400 && !done_seen; k++) begin
      if (abort_at >= 0 && received == abort_at) return;
      st = (restart_at >= 0 && !restarted && received == restart_at);
      if (st) restarted = 1;
      run_cycle(ready_of(mode, k), st, k);
      if (k == 1) check({tag, "_busy_run"}, 32'(s_busy), 32'd1);
      if (mode == 2 && k == 10) begin
        check({tag, "_stall_reads"}, 32'(issued), 32'd2);
        check({tag, "_stall_addr0"}, 32'(iss_addr[0]), 32'd0);
        check({tag, "_stall_addr1"}, 32'(iss_addr[1]), 32'd1);
        check({tag, "_stall_valid"}, 32'(s_valid), 32'd1);
        check({tag, "_stall_data"}, 32'(s_data), 32'h0100);
      end
      if (s_done === 1'b1) done_seen = 1;
    end
    check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
    run_cycle(1'b1, 1'b0, k);
    check({tag, "_busy_after"}, 32'(s_busy), 32'd0);
    check({tag, "_en_idle"}, 32'(s_en), 32'd0);
    check({tag, "_words"}, 32'(received), 32'(DEPTH));
    check({tag, "_reads"}, 32'(issued), 32'(DEPTH));
    check({tag, "_done_count"}, 32'(done_n), 32'd1);
    check({tag, "_credit"}, 32'(credit_viol), 32'd0);
    check({tag, "_first_lat"}, 32'(first_valid), 32'd2);
    for (int i = 0; i < DEPTH && i < received; i++) begin
      check($sformatf("%s_data%0d", tag, i), 32'(rx_data[i]), 32'h0100 + 32'(i));
      check($sformatf("%s_last%0d", tag, i), 32'(rx_last[i]), 32'(i == DEPTH - 1));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},  32'(BUSY),          32'd0);
    check({tag, "_done"},  32'(DONE),          32'd0);
    check({tag, "_en"},    32'(bus.BRAM_EN),   32'd0);
    check({tag, "_addr"},  32'(bus.BRAM_ADDR), 32'd0);
    check({tag, "_valid"}, 32'(bus.W_VALID),   32'd0);
    check({tag, "_last"},  32'(bus.W_LAST),    32'd0);
    check({tag, "_data"},  32'(bus.W_DATA),    32'd0);
  endtask

  initial begin
    for (int a = 0; a < 32; a++) mem[a] = 16'h0100 + 16'(a);
    RSTN        = 1'b0;
    START       = 1'b0;
    bus.W_READY = 1'b0;
    #3;
    check_reset_outputs("por");
    @(posedge CLK);
    @(posedge CLK);
    #2;
    RSTN = 1'b1;

    // Back-to-back stream with the consumer always ready.
    stream(0, -1, -1, "full_rate");
    // Consumer ready pattern 1,0,0,1.
    stream(1, -1, -1, "toggle");
    // Consumer stalls for ten cycles after START.
    stream(2, -1, -1, "stall");
    // Second START at word 5 must be ignored.
    stream(0, 5, -1, "restart");

    // Reset in the middle of a stream, asserted away from the clock edge.
    stream(0, -1, 12, "abort");
    @(negedge CLK);
    #1;
    RSTN = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    @(posedge CLK);
    #2;
    RSTN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle(1'b1, 1'b0, 0);
      check($sformatf("wait_busy%0d", i), 32'(s_busy), 32'd0);
      check($sformatf("wait_en%0d", i), 32'(s_en), 32'd0);
    end
    stream(0, -1, -1, "post_rst");

    check("bram_we", 32'(we_bad), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_weight_stream_reader
